// File: rtl/sdram_slot_pkg.sv
// Shared types and constants for the SDRAM slot arbiter.
//   slot_owner_t : which party owns the current 8-clk slot
//   PH_LAST      : last phase of a slot (the decision/capture phase)
//   SYNC_HIGH_PHASES : number of phases mem_sync is high at slot start
//   SLOT_LEN     : clocks per slot; PH_W is the derived phase counter width
package sdram_slot_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_REFRESH,
    OWN_DMA,
    OWN_CPU
  } slot_owner_t;

  localparam logic [2:0] PH_LAST          = 3'd7;
  localparam int         SYNC_HIGH_PHASES = 4;
  localparam int         SLOT_LEN         = 8;
  localparam int         PH_W             = $clog2(SLOT_LEN);

endpackage

// File: rtl/sdram_slot_timer.sv
// Slot timing for the SDRAM slot arbiter.
//   clk, reset_n : system clock, asynchronous active-low reset
//   slot_end     : high during the last phase of every slot
//   mem_sync     : registered slot sync, high in phases 0-3
//   init_done    : high once INIT_SLOTS slot boundaries have elapsed
module sdram_slot_timer
  import sdram_slot_pkg::*;
#(
  parameter int INIT_SLOTS = 32
) (
  input  logic clk,
  input  logic reset_n,
  output logic slot_end,
  output logic mem_sync,
  output logic init_done
);

  localparam int INIT_W = $clog2(INIT_SLOTS + 1);

  logic [PH_W-1:0]   phase;
  logic [PH_W-1:0]   phase_next;
  logic [INIT_W-1:0] init_cnt;

  assign phase_next = phase + PH_W'(1);
  assign slot_end   = (phase == PH_LAST);
  assign init_done  = (init_cnt == '0);

  // mem_sync is computed from the upcoming phase so the registered value
  // lines up with the phase register itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase    <= '0;
      mem_sync <= 1'b0;
      init_cnt <= INIT_W'(INIT_SLOTS);
    end else begin
      phase    <= phase_next;
      mem_sync <= (phase_next < PH_W'(SYNC_HIGH_PHASES));
      if (slot_end && (init_cnt != '0)) begin
        init_cnt <= init_cnt - INIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sdram_slot_arbiter.sv
// Chipset-side initiator for the 8-cycle SDRAM slot controller.
// Arbitrates a DMA read port and a CPU read/write port onto one slot per
// 8 clocks, forces idle slots during controller init and for refresh, and
// returns read data with a one-clock ack at the start of the next slot.
//   clk, reset_n           : 64 MHz clock, asynchronous active-low reset
//   dma_req/addr           : DMA read request (held until dma_ack)
//   dma_ack/rdata          : DMA completion pulse and read data
//   cpu_req/we/addr/ds/wdata : CPU request (held until cpu_ack)
//   cpu_ack/rdata          : CPU completion pulse and read data (reads)
//   mem_sync/oe/we/addr/ds/din : request bus to the SDRAM controller
//   mem_dout               : read data from the controller (valid phase 7)
//   init_done              : controller init window has elapsed
module sdram_slot_arbiter
  import sdram_slot_pkg::*;
#(
  parameter int INIT_SLOTS       = 32,
  parameter int REFRESH_INTERVAL = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dma_req,
  input  logic [23:0] dma_addr,
  output logic        dma_ack,
  output logic [15:0] dma_rdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [23:0] cpu_addr,
  input  logic [1:0]  cpu_ds,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  output logic        mem_sync,
  output logic        mem_oe,
  output logic        mem_we,
  output logic [23:0] mem_addr,
  output logic [1:0]  mem_ds,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,
  output logic        init_done
);

  localparam int              REF_W   = $clog2(REFRESH_INTERVAL + 1);
  localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_INTERVAL - 1);

  logic        slot_end;
  slot_owner_t owner;
  slot_owner_t owner_next;
  slot_owner_t last_grant;
  logic [REF_W-1:0] ref_cnt;
  logic        dma_eff;
  logic        cpu_eff;
  logic        force_idle;
  logic        busy_next;

  sdram_slot_timer #(
    .INIT_SLOTS(INIT_SLOTS)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .slot_end (slot_end),
    .mem_sync (mem_sync),
    .init_done(init_done)
  );

  // Slot decision. The owner of the ending slot is acked on this very edge,
  // but its requester only sees the ack afterwards and still holds req, so
  // that port is masked to avoid re-issuing the same request.
  always_comb begin
    owner_next = owner;
    dma_eff    = dma_req && (owner != OWN_DMA);
    cpu_eff    = cpu_req && (owner != OWN_CPU);
    force_idle = !init_done || (ref_cnt == REF_MAX);
    if (slot_end) begin
      if (force_idle) begin
        owner_next = OWN_REFRESH;
      end else if (dma_eff && !(cpu_eff && (last_grant == OWN_DMA))) begin
        owner_next = OWN_DMA;
      end else if (cpu_eff) begin
        owner_next = OWN_CPU;
      end else begin
        owner_next = OWN_NONE;
      end
    end
  end

  assign busy_next = (owner_next == OWN_DMA) || (owner_next == OWN_CPU);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner      <= OWN_NONE;
      last_grant <= OWN_DMA;
    end else begin
      owner <= owner_next;
      if (slot_end && busy_next) begin
        last_grant <= owner_next;
      end
    end
  end

  // Consecutive busy slot count; reaching REF_MAX forces the next slot idle
  // so the controller can auto-refresh.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_cnt <= '0;
    end else if (slot_end) begin
      if (busy_next) begin
        if (ref_cnt != REF_MAX) begin
          ref_cnt <= ref_cnt + REF_W'(1);
        end
      end else begin
        ref_cnt <= '0;
      end
    end
  end

  // Request bus: loaded at the slot boundary and held for all 8 phases.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_oe   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_ds   <= '0;
      mem_din  <= '0;
    end else if (slot_end) begin
      case (owner_next)
        OWN_DMA: begin
          mem_oe   <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= dma_addr;
          mem_ds   <= 2'b11;
          mem_din  <= '0;
        end
        OWN_CPU: begin
          mem_oe   <= !cpu_we;
          mem_we   <= cpu_we;
          mem_addr <= cpu_addr;
          mem_ds   <= cpu_we ? cpu_ds : 2'b11;
          mem_din  <= cpu_wdata;
        end
        default: begin
          mem_oe   <= 1'b0;
          mem_we   <= 1'b0;
          mem_addr <= '0;
          mem_ds   <= '0;
          mem_din  <= '0;
        end
      endcase
    end
  end

  // Capture at the end of phase 7; the ack lands in the next phase 0.
  // mem_we still reflects the ending slot here, so CPU writes leave
  // cpu_rdata untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dma_ack   <= 1'b0;
      cpu_ack   <= 1'b0;
      dma_rdata <= '0;
      cpu_rdata <= '0;
    end else begin
      dma_ack <= slot_end && (owner == OWN_DMA);
      cpu_ack <= slot_end && (owner == OWN_CPU);
      if (slot_end && (owner == OWN_DMA)) begin
        dma_rdata <= mem_dout;
      end
      if (slot_end && (owner == OWN_CPU) && !mem_we) begin
        cpu_rdata <= mem_dout;
      end
    end
  end

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Self-checking bench for sdram_slot_arbiter (INIT_SLOTS=32,
// REFRESH_INTERVAL=4). Stimulus pushes expected acks (port, data, cycle)
// into a scoreboard; a monitor pops and compares on every ack.
module tb_sdram_slot_arbiter;

  logic        clk;
  logic        reset_n;
  logic        dma_req;
  logic [23:0] dma_addr;
  logic        dma_ack;
  logic [15:0] dma_rdata;
  logic        cpu_req;
  logic        cpu_we;
  logic [23:0] cpu_addr;
  logic [1:0]  cpu_ds;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        mem_sync;
  logic        mem_oe;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [1:0]  mem_ds;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic        init_done;

  int checks   = 0;
  int failures = 0;
  int cyc;

  typedef struct packed {
    logic        is_cpu;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  sdram_slot_arbiter #(
    .INIT_SLOTS      (32),
    .REFRESH_INTERVAL(4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .dma_req  (dma_req),
    .dma_addr (dma_addr),
    .dma_ack  (dma_ack),
    .dma_rdata(dma_rdata),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_ds   (cpu_ds),
    .cpu_wdata(cpu_wdata),
    .cpu_ack  (cpu_ack),
    .cpu_rdata(cpu_rdata),
    .mem_sync (mem_sync),
    .mem_oe   (mem_oe),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_ds   (mem_ds),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .init_done(init_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Clocks since reset release; after edge n the DUT is in phase n%8.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  function automatic logic [15:0] rd_model(input logic [23:0] a);
    if (a == 24'h000010) return 16'hBEEF;
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [79:0] pack_outs();
    return {mem_sync, mem_oe, mem_we, mem_addr, mem_ds, mem_din,
            dma_ack, cpu_ack, dma_rdata, cpu_rdata, init_done};
  endfunction

  task automatic check(input string name, input logic [79:0] act,
                       input logic [79:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Controller model: read data is garbage until phase 6, then valid.
  initial begin
    mem_dout = 16'hDEAD;
    forever begin
      @(posedge clk);
      #1;
      if (cyc[2:0] == 3'd6)
        mem_dout = mem_oe ? rd_model(mem_addr) : 16'hDEAD;
      else if (cyc[2:0] != 3'd7)
        mem_dout = 16'hDEAD;
    end
  end

  // Monitor: pops one expectation per ack.
  initial begin
    logic prev_ack;
    exp_t e;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (dma_ack || cpu_ack) begin
        check("ack_single", 80'(dma_ack & cpu_ack), 80'(0));
        check("ack_width", 80'(prev_ack), 80'(0));
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL ack_unexpected actual=ack at cyc %0d required=no ack", cyc);
        end else begin
          e = sb.pop_front();
          check("ack_port", 80'(cpu_ack), 80'(e.is_cpu));
          check("ack_data", 80'(cpu_ack ? cpu_rdata : dma_rdata), 80'(e.data));
          check("ack_cycle", 80'(cyc), 80'(e.cyc));
        end
      end
      prev_ack = dma_ack | cpu_ack;
    end
  end

  task automatic align();
    do @(negedge clk); while (cyc[2:0] != 3'd1);
  endtask

  initial begin
    int early_busy, sync_err, done_cyc, oe_cyc, c, err, acks, busy;
    int slot_kind [12] = '{1, 2, 1, 0, 2, 1, 2, 0, 1, 2, 1, 0};
    logic [27:0] exp_v, act_v;
    exp_t e;

    reset_n = 1'b0;
    dma_req = 1'b0; dma_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_ds = '0; cpu_wdata = '0;

    // Reset state and init window with a CPU read pending throughout.
    repeat (3) @(negedge clk);
    check("reset_outputs", pack_outs(), 80'(0));
    cpu_req = 1'b1; cpu_addr = 24'h000010;
    e = '{is_cpu: 1'b1, data: 16'hBEEF, cyc: 272};
    sb.push_back(e);
    reset_n = 1'b1;
    early_busy = 0; sync_err = 0; done_cyc = -1; oe_cyc = -1;
    repeat (280) begin
      @(negedge clk);
      if (cyc < 264 && (mem_oe || mem_we)) early_busy++;
      if (mem_sync != (cyc[2:0] < 3'd4)) sync_err++;
      if (init_done && done_cyc < 0) done_cyc = cyc;
      if (mem_oe && oe_cyc < 0) oe_cyc = cyc;
      if (cyc == 265)
        check("init_read_drive", 80'({mem_we, mem_ds, mem_addr}),
              80'({1'b0, 2'b11, 24'h000010}));
      if (cpu_ack) cpu_req = 1'b0;
    end
    check("init_idle_slots", 80'(early_busy), 80'(0));
    check("sync_pattern", 80'(sync_err), 80'(0));
    check("init_done_cycle", 80'(done_cyc), 80'(256));
    check("init_grant_cycle", 80'(oe_cyc), 80'(264));
    check("init_sb_drained", 80'(sb.size()), 80'(0));

    // Byte write: drive held for the whole slot, single ack, rdata kept.
    align();
    c = cyc;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_ds = 2'b01;
    cpu_addr = 24'h123456; cpu_wdata = 16'hA55A;
    e = '{is_cpu: 1'b1, data: 16'hBEEF, cyc: c + 15};
    sb.push_back(e);
    err = 0; acks = 0; busy = 0;
    repeat (22) begin
      @(negedge clk);
      if (cyc >= c + 7 && cyc <= c + 14 &&
          {mem_we, mem_oe, mem_ds, mem_din, mem_addr} !==
          {1'b1, 1'b0, 2'b01, 16'hA55A, 24'h123456}) err++;
      if (cpu_ack) begin acks++; cpu_req = 1'b0; end
      if (cyc >= c + 15 && (mem_oe || mem_we)) busy++;
    end
    check("wr_drive", 80'(err), 80'(0));
    check("wr_ack_pulses", 80'(acks), 80'(1));
    check("wr_no_reissue", 80'(busy), 80'(0));
    check("wr_sb_drained", 80'(sb.size()), 80'(0));

    // Contention with refresh guard: D C D I C D C I D C D I.
    align();
    c = cyc;
    cpu_we = 1'b0; cpu_ds = 2'b00; cpu_addr = 24'h000300;
    dma_addr = 24'h000200;
    dma_req = 1'b1; cpu_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (slot_kind[k] != 0) begin
        e.is_cpu = (slot_kind[k] == 2);
        e.data   = rd_model(e.is_cpu ? 24'h000300 : 24'h000200);
        e.cyc    = c + 15 + 8 * k;
        sb.push_back(e);
      end
    end
    busy = 0;
    repeat (120) begin
      @(negedge clk);
      if (cyc >= c + 7 && ((cyc - c - 7) % 8) == 3 && ((cyc - c - 7) / 8) < 12) begin
        int k;
        k = (cyc - c - 7) / 8;
        act_v = {mem_oe, mem_we, mem_ds, mem_addr};
        case (slot_kind[k])
          1:       exp_v = {1'b1, 1'b0, 2'b11, 24'h000200};
          2:       exp_v = {1'b1, 1'b0, 2'b11, 24'h000300};
          default: begin exp_v = '0; act_v = {mem_oe, mem_we, 26'b0}; end
        endcase
        check($sformatf("slot%0d_drive", k), 80'(act_v), 80'(exp_v));
      end
      if (cyc == c + 96) begin dma_req = 1'b0; cpu_req = 1'b0; end
      if (cyc > c + 96 && (mem_oe || mem_we)) busy++;
    end
    check("cont_no_extra_slot", 80'(busy), 80'(0));
    check("cont_sb_drained", 80'(sb.size()), 80'(0));

    // Mid-slot reset during a CPU read: abort, no ack, init re-run.
    align();
    c = cyc;
    cpu_addr = 24'h000400; cpu_we = 1'b0; cpu_req = 1'b1;
    while (cyc != c + 11) @(negedge clk);
    check("midreset_slot_active", 80'(mem_oe), 80'(1));
    reset_n = 1'b0;
    #1;
    check("midreset_outputs", pack_outs(), 80'(0));
    cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    done_cyc = -1; busy = 0; acks = 0;
    repeat (270) begin
      @(negedge clk);
      if (init_done && done_cyc < 0) done_cyc = cyc;
      if (mem_oe || mem_we) busy++;
      if (cpu_ack || dma_ack) acks++;
    end
    check("midreset_no_ack", 80'(acks), 80'(0));
    check("midreset_idle", 80'(busy), 80'(0));
    check("midreset_init_done_cycle", 80'(done_cyc), 80'(256));
    check("final_sb_drained", 80'(sb.size()), 80'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
